// File: rtl/arm_pkg.sv
// Core-wide constants and shared types for the ARM pipeline.
// Fetch entries pair a 32-bit instruction word with its PC.
package arm_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] PC_READ_OFS      = 32'd8;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered prefetch FIFO of {instr, pc}; push lands a cycle before it is visible.
// The caller must not push when full unless it pops in the same cycle; flush empties it.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH[CW-1:0]);
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests, 2-cycle min grant-to-decode.
// Decode stalls hold the FIFO head; redirect flushes the queue and drops stale responses.
module fetch_unit
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        instr_pc8,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
);

  localparam int          CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] CREDITS = DEPTH[CW:0];

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  fetch_state_t  state;
  logic [CW:0]   credit_used;
  logic [31:0]   target;
  logic          gnt_fire;
  logic          rsp_ok;
  logic          push;
  logic          pop;

  assign state  = (drop_cnt != '0) ? ST_FLUSH : ST_RUN;
  assign target = word_align(redirect_pc);

  assign instr_valid = ~fifo_empty & ~redirect;
  assign pop         = instr_valid & instr_ready;

  // The entry leaving for decode this cycle frees its slot for a new request.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign imem_req    = reset_n & ~redirect & (credit_used < CREDITS);
  assign imem_addr   = fetch_pc;
  assign gnt_fire    = imem_req & imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok     = imem_rvalid & (outstanding != '0);
  assign push       = rsp_ok & ~redirect & (state == ST_RUN) & (~fifo_full | pop);
  assign push_entry = '{instr: imem_rdata, pc: resp_pc};

  assign instr     = head.instr;
  assign instr_pc  = head.pc;
  assign instr_pc8 = head.pc + PC_READ_OFS;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (redirect),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(gnt_fire) - CW'(rsp_ok);
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        // Everything still in flight after this edge belongs to the old stream.
        drop_cnt <= outstanding - CW'(rsp_ok);
      end else begin
        if (gnt_fire) begin
          fetch_pc <= fetch_pc + PC_INC;
        end
        if (push) begin
          resp_pc <= resp_pc + PC_INC;
        end
        if (rsp_ok && state == ST_FLUSH) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: in-order memory model with programmable latency,
// expected {pc, word} queue checked by an independent monitor on every decode transfer.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc8;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_pc8  (instr_pc8),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] drop;
    logic [31:0] outs;
  } smp_t;

  pend_t       pend[$];
  smp_t        lg[$];
  logic [31:0] expq[$];
  int          tests = 0;
  int          fails = 0;
  int          lat   = 1;
  int          b;
  int          ng;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE59F_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock cycle: present the memory response, sample, record grants, advance.
  task automatic step();
    smp_t  s;
    pend_t p;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!reset_n) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= lg.size()) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      pend.delete(0);
    end
    #1;
    s.req    = imem_req;
    s.gnt    = imem_gnt;
    s.rvalid = imem_rvalid;
    s.valid  = instr_valid;
    s.addr   = imem_addr;
    s.instr  = instr;
    s.pc     = instr_pc;
    s.pc8    = instr_pc8;
    s.drop   = 32'(dut.drop_cnt);
    s.outs   = 32'(dut.outstanding);
    if (imem_req && imem_gnt) begin
      p.addr = imem_addr;
      p.due  = lg.size() + lat;
      pend.push_back(p);
    end
    lg.push_back(s);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    redirect = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && expq.size() > 0; i++) step();
    chk(name, expq.size(), 0);
    expq.delete();
  endtask

  task automatic chk_rst(input int i);
    chk("rst_req", lg[i].req, 0);
    chk("rst_addr", lg[i].addr, 32'h100);
    chk("rst_valid", lg[i].valid, 0);
    chk("rst_instr", lg[i].instr, 0);
    chk("rst_pc", lg[i].pc, 0);
    chk("rst_pc8", lg[i].pc8, 32'h8);
    chk("rst_drop", lg[i].drop, 0);
    chk("rst_outs", lg[i].outs, 0);
  endtask

  // Monitor: every decode transfer must match the head of the expected queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL xfer_unexpected: got pc %h, want no transfer", instr_pc);
        end else begin
          e = expq.pop_front();
          if (instr !== mem_word(e) || instr_pc !== e || instr_pc8 !== e + 32'd8) begin
            fails++;
            $display("FAIL xfer: got pc %h pc8 %h instr %h, want pc %h pc8 %h instr %h",
                     instr_pc, instr_pc8, instr, e, e + 32'd8, mem_word(e));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);

    // Reset values, then streaming at one instruction per cycle.
    b = lg.size();
    step();
    chk_rst(b);
    reset_n = 1'b1;
    lat     = 1;
    for (int k = 0; k < 6; k++) expq.push_back(32'h100 + 32'(4 * k));
    b = lg.size();
    steps(6);
    imem_gnt = 1'b0;
    drain("s_drain");
    chk("s_req0", lg[b].req, 1);
    chk("s_addr0", lg[b].addr, 32'h100);
    chk("s_addr1", lg[b+1].addr, 32'h104);
    chk("s_addr2", lg[b+2].addr, 32'h108);
    chk("s_gnt2", lg[b+2].req & lg[b+2].gnt, 1);
    chk("s_valid1", lg[b+1].valid, 0);
    chk("s_valid2", lg[b+2].valid, 1);
    chk("s_pc2", lg[b+2].pc, 32'h100);
    chk("s_pc8_2", lg[b+2].pc8, 32'h108);
    ng = 0;
    for (int k = 2; k < 8; k++) ng += int'(lg[b+k].valid);
    chk("s_rate", ng, 6);

    // Backpressure: two grants fill the credits, then requests stop.
    do_reset();
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    lat         = 1;
    expq.push_back(32'h100);
    expq.push_back(32'h104);
    b = lg.size();
    steps(10);
    ng = 0;
    for (int k = 0; k < 10; k++) ng += int'(lg[b+k].req & lg[b+k].gnt);
    chk("bp_grants", ng, 2);
    chk("bp_req_off", lg[b+9].req, 0);
    chk("bp_hold_pc", lg[b+9].pc, 32'h100);
    imem_gnt    = 1'b0;
    instr_ready = 1'b1;
    drain("bp_drain");

    // Redirect with two stale responses in flight (3-cycle memory).
    do_reset();
    lat      = 3;
    imem_gnt = 1'b1;
    expq.push_back(32'h200);
    expq.push_back(32'h204);
    b = lg.size();
    steps(2);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    steps(3);
    imem_gnt = 1'b0;
    drain("rd_drain");
    chk("rd_req_forced", lg[b+2].req, 0);
    chk("rd_drop2", lg[b+3].drop, 2);
    chk("rd_stale_req", lg[b+3].req, 0);
    chk("rd_drop1", lg[b+4].drop, 1);
    chk("rd_addr", lg[b+4].addr, 32'h200);
    chk("rd_req", lg[b+4].req, 1);
    chk("rd_addr2", lg[b+5].addr, 32'h204);
    chk("rd_valid7", lg[b+7].valid, 0);
    chk("rd_pc8", lg[b+8].pc, 32'h200);

    // Redirect coinciding with a response and a ready decode (2-cycle memory).
    do_reset();
    lat      = 2;
    imem_gnt = 1'b1;
    expq.push_back(32'h300);
    b = lg.size();
    steps(3);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    step();
    imem_gnt = 1'b0;
    drain("sim_drain");
    chk("sim_rvalid", lg[b+3].rvalid, 1);
    chk("sim_outs", lg[b+3].outs, 1);
    chk("sim_valid", lg[b+3].valid, 0);
    chk("sim_req", lg[b+3].req, 0);
    chk("sim_drop", lg[b+4].drop, 0);
    chk("sim_addr", lg[b+4].addr, 32'h300);

    // Grant stall at the top of the address space, then wrap to zero.
    do_reset();
    lat      = 1;
    imem_gnt = 1'b0;
    expq.push_back(32'hFFFF_FFFC);
    expq.push_back(32'h0000_0000);
    b           = lg.size();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    steps(3);
    imem_gnt = 1'b1;
    steps(2);
    imem_gnt = 1'b0;
    drain("wr_drain");
    for (int k = 1; k < 4; k++) begin
      chk("wr_stall_addr", lg[b+k].addr, 32'hFFFF_FFFC);
      chk("wr_stall_req", lg[b+k].req, 1);
    end
    chk("wr_addr_gnt", lg[b+4].addr, 32'hFFFF_FFFC);
    chk("wr_addr_wrap", lg[b+5].addr, 32'h0);
    chk("wr_pc", lg[b+6].pc, 32'hFFFF_FFFC);
    chk("wr_pc8", lg[b+6].pc8, 32'h4);

    // Reset pulse while two stale responses are pending.
    do_reset();
    lat      = 3;
    imem_gnt = 1'b1;
    b        = lg.size();
    steps(2);
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    chk("mf_pre_drop", 32'(dut.drop_cnt), 2);
    reset_n = 1'b0;
    step();
    chk_rst(b + 3);
    reset_n = 1'b1;
    lat     = 1;
    expq.push_back(32'h100);
    step();
    imem_gnt = 1'b0;
    drain("mf_drain");
    chk("mf_req", lg[b+4].req, 1);
    chk("mf_addr", lg[b+4].addr, 32'h100);
    chk("mf_drop", lg[b+4].drop, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
